blocks_ctl: RTL and testbench
=============================

// Module: blocks_ctl
// PURPOSE
//  Block-state manager for Arkanoid; sits directly upstream of draw_board and drives its blocks_in.
//  Once per frame it checks the ball box against the 4x4 brick grid.
//  On a hit it marks the first live brick it finds as destroyed (at most one per frame).
//  It reports the bounce axis to the ball logic, the destroyed-brick count and the all-cleared flag.
// PARAMETERS
//  X0        112  left edge of column 0 (px)
//  Y0        60   top edge of row 0 (px)
//  X_PITCH   150  column-to-column distance (px)
//  Y_PITCH   70   row-to-row distance (px)
//  B_WIDTH   100  brick width; brick spans [Xc, Xc+B_WIDTH], inclusive
//  B_HEIGHT  50   brick height; brick spans [Yr, Yr+B_HEIGHT], inclusive
//  BALL_SIZE 16   ball box side; ball spans [bx, bx+BALL_SIZE-1]
// PORTS
//  pclk        in   1   pixel clock; the only clock
//  reset       in   1   asynchronous, active-high reset
//  frame_tick  in   1   1-cycle pulse at start of vblank; starts a check
//  new_game    in   1   1-cycle pulse; restores all bricks
//  ball_x      in   11  ball box left x (px)
//  ball_y      in   11  ball box top y (px)
//  blocks_out  out  16  1 = brick destroyed; bit index = row*4+col (bit0 = r0c0, bit12 = r3c0)
//  hit_valid   out  1   1-cycle pulse: a brick was destroyed
//  hit_index   out  4   index of the destroyed brick; valid with hit_valid
//  bounce_x    out  1   reverse ball x velocity; valid with hit_valid
//  bounce_y    out  1   reverse ball y velocity; valid with hit_valid
//  scan_done   out  1   1-cycle pulse: frame check finished (hit or no hit)
//  score       out  5   destroyed-brick count, 0..16
//  all_cleared out  1   1 when blocks_out == 16'hFFFF
// BEHAVIOUR
//  Reset: all outputs 0; FSM goes to IDLE; asserting reset aborts any scan in progress.
//  FSM states: IDLE, LATCH, SCAN, HIT, DONE.
//   IDLE:  frame_tick -> LATCH.
//   LATCH: register ball_x/ball_y; clear idx; -> SCAN.
//   SCAN:  test brick idx each cycle, idx = 0..15 ascending.
//          First live overlapping brick -> HIT. idx==15 with no hit -> DONE.
//   HIT:   set blocks_out[idx]; pulse hit_valid; drive hit_index/bounce_*; score+1; -> DONE.
//   DONE:  pulse scan_done; -> IDLE.
//  Timing, frame_tick at cycle T: brick k is tested in cycle T+2+k.
//   Hit on brick k: hit_valid, blocks_out update and scan_done all appear at T+3+k.
//   No hit: scan_done at T+18.
//  Overlap test: all comparisons are 12-bit unsigned, so sums cannot overflow.
//   Brick k has Xc = X0+col*X_PITCH and Yr = Y0+row*Y_PITCH.
//   Hit if !blocks_out[k] && bx+BALL_SIZE-1 >= Xc && bx <= Xc+B_WIDTH
//   && by+BALL_SIZE-1 >= Yr && by <= Yr+B_HEIGHT.
//  Bounce axis: cx = bx + BALL_SIZE/2.
//   cx in [Xc, Xc+B_WIDTH] -> bounce_y=1, bounce_x=0; otherwise bounce_x=1, bounce_y=0.
//   Exactly one of bounce_x/bounce_y is 1 while hit_valid=1; both are 0 otherwise.
//  Simultaneous overlaps: only the lowest live index is destroyed; the rest wait for later frames.
//  Ignored inputs: frame_tick outside IDLE; ball_x/ball_y changes after LATCH.
//  new_game (synchronous, beats frame_tick): next cycle blocks_out=0, score=0, all_cleared=0,
//   pulses cleared, FSM to IDLE (an active scan is aborted).
//  all_cleared: registered; updates in the same cycle as blocks_out. score saturates at 16.
//  Destroyed bricks are never restored except by new_game or reset.
// TESTING (default parameters)
//  1. Ball (150,80), tick at T -> T+3: hit_valid=1, hit_index=0, blocks_out=16'h0001, bounce_y=1, score=1.
//  2. Ball (100,80) [cx=108 < 112] -> hit on index 0 with bounce_x=1, bounce_y=0.
//  3. Ball (0,500) -> no hit_valid; scan_done at T+18; blocks_out unchanged.
//  4. Block0 already destroyed, ball (150,80) -> no hit; scan_done at T+18. Ball (562,270) -> hit_index=15, blocks_out bit15 set.
//  5. Destroy all 16 bricks -> score=16, all_cleared=1. new_game -> next cycle blocks_out=0, score=0, all_cleared=0.
//  6. Reset asserted at T+6 during a scan -> outputs 0 immediately; no hit_valid/scan_done; next frame_tick runs a full scan.

Source files
------------

// File: rtl/blocks_ctl.sv
// Arkanoid brick-state manager: once per frame scans the 4x4 brick grid against the
// ball box, destroys the first live overlapping brick and reports bounce axis and score.
module blocks_ctl #(
   parameter int X0        = 112,
   parameter int Y0        = 60,
   parameter int X_PITCH   = 150,
   parameter int Y_PITCH   = 70,
   parameter int B_WIDTH   = 100,
   parameter int B_HEIGHT  = 50,
   parameter int BALL_SIZE = 16
) (
   input  logic        pclk,
   input  logic        reset,
   input  logic        frame_tick,
   input  logic        new_game,
   input  logic [10:0] ball_x,
   input  logic [10:0] ball_y,
   output logic [15:0] blocks_out,
   output logic        hit_valid,
   output logic [3:0]  hit_index,
   output logic        bounce_x,
   output logic        bounce_y,
   output logic        scan_done,
   output logic [4:0]  score,
   output logic        all_cleared,
   output logic [2:0]  state_dbg
);

   typedef enum logic [2:0] {IDLE, LATCH, SCAN, HIT, DONE} state_t;

   state_t      state;
   logic [3:0]  idx;
   logic [11:0] bx, by;
   logic [11:0] xc, yr, cx;
   logic        overlap, hit_now, cx_inside;
   logic [15:0] blocks_next;

   // Brick origin for the brick under test; all arithmetic is 12-bit unsigned.
   always_comb begin
      xc        = 12'(X0) + 12'(X_PITCH) * {10'd0, idx[1:0]};
      yr        = 12'(Y0) + 12'(Y_PITCH) * {10'd0, idx[3:2]};
      cx        = bx + 12'(BALL_SIZE / 2);
      overlap   = (bx + 12'(BALL_SIZE - 1) >= xc) && (bx <= xc + 12'(B_WIDTH)) &&
                  (by + 12'(BALL_SIZE - 1) >= yr) && (by <= yr + 12'(B_HEIGHT));
      hit_now   = overlap && !blocks_out[idx];
      cx_inside = (cx >= xc) && (cx <= xc + 12'(B_WIDTH));
      blocks_next = blocks_out | (16'd1 << idx);
   end

   assign state_dbg = state;

   // Results are registered on leaving SCAN, so they appear the cycle after the brick is tested.
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         idx         <= 4'd0;
         bx          <= 12'd0;
         by          <= 12'd0;
         blocks_out  <= 16'd0;
         hit_valid   <= 1'b0;
         hit_index   <= 4'd0;
         bounce_x    <= 1'b0;
         bounce_y    <= 1'b0;
         scan_done   <= 1'b0;
         score       <= 5'd0;
         all_cleared <= 1'b0;
      end else begin
         hit_valid <= 1'b0;
         scan_done <= 1'b0;
         bounce_x  <= 1'b0;
         bounce_y  <= 1'b0;
         if (new_game) begin
            state       <= IDLE;
            idx         <= 4'd0;
            blocks_out  <= 16'd0;
            hit_index   <= 4'd0;
            score       <= 5'd0;
            all_cleared <= 1'b0;
         end else begin
            case (state)
               IDLE: if (frame_tick) state <= LATCH;
               LATCH: begin
                  bx    <= {1'b0, ball_x};
                  by    <= {1'b0, ball_y};
                  idx   <= 4'd0;
                  state <= SCAN;
               end
               SCAN: begin
                  if (hit_now) begin
                     blocks_out  <= blocks_next;
                     all_cleared <= (blocks_next == 16'hFFFF);
                     hit_valid   <= 1'b1;
                     hit_index   <= idx;
                     bounce_y    <= cx_inside;
                     bounce_x    <= !cx_inside;
                     scan_done   <= 1'b1;
                     if (score != 5'd16) score <= score + 5'd1;
                     state       <= HIT;
                  end else if (idx == 4'd15) begin
                     scan_done <= 1'b1;
                     state     <= DONE;
                  end else begin
                     idx <= idx + 4'd1;
                  end
               end
               HIT:     state <= IDLE;
               DONE:    state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_blocks_ctl.sv
// Directed bench for blocks_ctl: table of frames with hand-computed results, plus
// sequences for clear-all, new_game abort/clear and reset during a scan.
module tb_blocks_ctl;

   logic        pclk = 1'b0;
   logic        reset;
   logic        frame_tick;
   logic        new_game;
   logic [10:0] ball_x, ball_y;
   logic [15:0] blocks_out;
   logic        hit_valid;
   logic [3:0]  hit_index;
   logic        bounce_x, bounce_y, scan_done;
   logic [4:0]  score;
   logic        all_cleared;
   logic [2:0]  state_dbg;

   int total = 0;
   int bad   = 0;
   logic [15:0] exp_q[$];

   blocks_ctl dut (
      .pclk(pclk), .reset(reset), .frame_tick(frame_tick), .new_game(new_game),
      .ball_x(ball_x), .ball_y(ball_y), .blocks_out(blocks_out), .hit_valid(hit_valid),
      .hit_index(hit_index), .bounce_x(bounce_x), .bounce_y(bounce_y),
      .scan_done(scan_done), .score(score), .all_cleared(all_cleared),
      .state_dbg(state_dbg)
   );

   always #5 pclk = ~pclk;

   typedef struct {
      logic [10:0] bx;
      logic [10:0] by;
      logic        hit;
      logic [3:0]  idx;
      logic        bnc_x;
      logic        bnc_y;
      logic [15:0] blocks;
      logic [4:0]  score;
      int          done_cyc;
      logic        newg;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pulse_new_game();
      @(negedge pclk);
      new_game = 1'b1;
      @(negedge pclk);
      new_game = 1'b0;
   endtask

   // Tick at cycle T; the n-th following negedge lies in cycle T+n.
   task automatic run_frame(input logic [10:0] x, input logic [10:0] y,
                            output int hit_cyc, output int done_cyc,
                            output logic [3:0] h_idx, output logic h_bx, output logic h_by,
                            output int stray);
      hit_cyc = 0; done_cyc = 0; h_idx = 4'd0; h_bx = 1'b0; h_by = 1'b0; stray = 0;
      @(negedge pclk);
      ball_x = x; ball_y = y; frame_tick = 1'b1;
      for (int n = 1; n <= 30 && done_cyc == 0; n++) begin
         @(negedge pclk);
         frame_tick = 1'b0;
         if (n == 2) begin
            ball_x = ~x;
            ball_y = ~y;
         end
         if (hit_valid) begin
            hit_cyc = n; h_idx = hit_index; h_bx = bounce_x; h_by = bounce_y;
         end else if (bounce_x || bounce_y) begin
            stray++;
         end
         if (scan_done) done_cyc = n;
         if (n == 4 && done_cyc == 0) frame_tick = 1'b1;
      end
      frame_tick = 1'b0;
   endtask

   task automatic quiet_window(input string name, input int cycles);
      int pulses;
      pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge pclk);
         if (hit_valid || scan_done) pulses++;
      end
      check(name, pulses, 0);
   endtask

   task automatic apply_frame(input string name, input logic [10:0] x, input logic [10:0] y,
                              input logic e_hit, input logic [3:0] e_idx,
                              input logic e_bx, input logic e_by, input logic [4:0] e_score,
                              input int e_done, input logic e_clr);
      int hc, dc, st;
      logic [3:0] hi;
      logic hbx, hby;
      logic [15:0] e_blocks;
      run_frame(x, y, hc, dc, hi, hbx, hby, st);
      e_blocks = exp_q.pop_front();
      check({name, " done_cyc"}, dc, e_done);
      check({name, " hit_cyc"}, hc, e_hit ? e_done : 0);
      if (e_hit) begin
         check({name, " hit_index"}, hi, e_idx);
         check({name, " bounce"}, {hbx, hby}, {e_bx, e_by});
      end
      check({name, " stray_bounce"}, st, 0);
      check({name, " blocks_out"}, blocks_out, e_blocks);
      check({name, " score"}, score, e_score);
      check({name, " all_cleared"}, all_cleared, e_clr);
      quiet_window({name, " quiet"}, 20);
   endtask

   initial begin
      //            bx    by   hit idx bx by  blocks    score done newg
      vecs[0]  = '{11'd150, 11'd80,  1'b1, 4'd0,  1'b0, 1'b1, 16'h0001, 5'd1, 3,  1'b0};
      vecs[1]  = '{11'd150, 11'd80,  1'b0, 4'd0,  1'b0, 1'b0, 16'h0001, 5'd1, 18, 1'b0};
      vecs[2]  = '{11'd562, 11'd270, 1'b1, 4'd15, 1'b0, 1'b1, 16'h8001, 5'd2, 18, 1'b0};
      vecs[3]  = '{11'd0,   11'd500, 1'b0, 4'd0,  1'b0, 1'b0, 16'h8001, 5'd2, 18, 1'b0};
      vecs[4]  = '{11'd100, 11'd80,  1'b1, 4'd0,  1'b1, 1'b0, 16'h0001, 5'd1, 3,  1'b1};
      vecs[5]  = '{11'd270, 11'd140, 1'b1, 4'd5,  1'b0, 1'b1, 16'h0021, 5'd2, 8,  1'b0};
      vecs[6]  = '{11'd397, 11'd210, 1'b1, 4'd10, 1'b1, 1'b0, 16'h0421, 5'd3, 13, 1'b0};
      vecs[7]  = '{11'd512, 11'd140, 1'b1, 4'd6,  1'b1, 1'b0, 16'h0461, 5'd4, 9,  1'b0};
      vecs[8]  = '{11'd663, 11'd140, 1'b0, 4'd0,  1'b0, 1'b0, 16'h0461, 5'd4, 18, 1'b0};
      vecs[9]  = '{11'd570, 11'd110, 1'b1, 4'd3,  1'b0, 1'b1, 16'h0469, 5'd5, 6,  1'b0};
      vecs[10] = '{11'd150, 11'd255, 1'b1, 4'd12, 1'b0, 1'b1, 16'h1469, 5'd6, 15, 1'b0};
      vecs[11] = '{11'd270, 11'd254, 1'b0, 4'd0,  1'b0, 1'b0, 16'h1469, 5'd6, 18, 1'b0};

      // clock/reset
      reset = 1'b1; frame_tick = 1'b0; new_game = 1'b0; ball_x = 11'd0; ball_y = 11'd0;
      #2;
      check("reset blocks_out", blocks_out, 16'h0000);
      check("reset score", score, 5'd0);
      check("reset pulses", {hit_valid, scan_done, bounce_x, bounce_y, all_cleared}, 5'd0);
      check("reset hit_index", hit_index, 4'd0);
      check("reset state", state_dbg, 3'd0);
      repeat (2) @(negedge pclk);
      reset = 1'b0;

      // table-driven frames
      for (int v = 0; v < 12; v++) begin
         if (vecs[v].newg) pulse_new_game();
         exp_q.push_back(vecs[v].blocks);
         apply_frame($sformatf("vec%0d", v), vecs[v].bx, vecs[v].by, vecs[v].hit,
                     vecs[v].idx, vecs[v].bnc_x, vecs[v].bnc_y, vecs[v].score,
                     vecs[v].done_cyc, 1'b0);
      end

      // clear all 16 bricks from a fresh game
      begin
         logic [15:0] model;
         model = 16'h0000;
         pulse_new_game();
         for (int k = 0; k < 16; k++) begin
            model = model | (16'd1 << k);
            exp_q.push_back(model);
            apply_frame($sformatf("clear%0d", k), 11'(112 + 150 * (k % 4) + 10),
                        11'(60 + 70 * (k / 4) + 10), 1'b1, 4'(k), 1'b0, 1'b1,
                        5'(k + 1), 3 + k, k == 15);
         end
         exp_q.push_back(16'hFFFF);
         apply_frame("after_clear", 11'd150, 11'd80, 1'b0, 4'd0, 1'b0, 1'b0, 5'd16, 18, 1'b1);
      end

      // new_game clears on the following cycle
      @(negedge pclk);
      new_game = 1'b1;
      @(negedge pclk);
      new_game = 1'b0;
      check("new_game blocks_out", blocks_out, 16'h0000);
      check("new_game score", score, 5'd0);
      check("new_game all_cleared", all_cleared, 1'b0);

      // new_game aborts a scan in progress (brick 5 would hit at T+8)
      @(negedge pclk);
      ball_x = 11'd270; ball_y = 11'd140; frame_tick = 1'b1;
      for (int n = 1; n <= 4; n++) begin
         @(negedge pclk);
         frame_tick = 1'b0;
      end
      new_game = 1'b1;
      @(negedge pclk);
      new_game = 1'b0;
      check("abort state", state_dbg, 3'd0);
      quiet_window("abort quiet", 20);
      check("abort blocks_out", blocks_out, 16'h0000);

      // reset at T+6 during a scan, with some bricks already down
      exp_q.push_back(16'h0001);
      apply_frame("pre_reset", 11'd150, 11'd80, 1'b1, 4'd0, 1'b0, 1'b1, 5'd1, 3, 1'b0);
      @(negedge pclk);
      ball_x = 11'd420; ball_y = 11'd210; frame_tick = 1'b1;
      for (int n = 1; n <= 6; n++) begin
         @(negedge pclk);
         frame_tick = 1'b0;
      end
      reset = 1'b1;
      #1;
      check("midscan reset blocks_out", blocks_out, 16'h0000);
      check("midscan reset score", score, 5'd0);
      check("midscan reset state", state_dbg, 3'd0);
      repeat (2) @(negedge pclk);
      reset = 1'b0;
      quiet_window("post_reset quiet", 20);
      exp_q.push_back(16'h0400);
      apply_frame("post_reset", 11'd420, 11'd210, 1'b1, 4'd10, 1'b0, 1'b1, 5'd1, 13, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
